csa_slice_sequencer: RTL and testbench

Multi-cycle wide adder/subtractor that time-multiplexes a single 4-bit carry-select slice across a W-bit operand, one slice per clock, least-significant slice first. Sits between an operand producer and a result consumer, each attached by a valid/ready handshake. Replaces a full-width adder where area matters more than latency. Produces the W-bit sum, carry-out and signed overflow.

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_slice_sequencer_if.sv | 28 ++
 rtl/csa_slice4.sv | 34 +++
 rtl/csa_slice_sequencer.sv | 104 ++++++++++
 tb/tb_csa_slice_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared constants for the carry-select slice sequencer: state encoding,
// slice width and the slice-count helper.
package csa_pkg;

    localparam int SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int nslice(input int w);
        return w / SLICE_W;
    endfunction

endpackage

// File: rtl/csa_slice_sequencer_if.sv
// Operand/result handshake bundle between producer, sequencer and consumer.
// The master side drives operands and takes results; the slave side is the sequencer.
interface csa_slice_sequencer_if #(parameter int W = 16);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/csa_slice4.sv
// Combinational 4-bit carry-select slice: both carry-in cases are rippled in
// parallel and the registered carry picks one.
module csa_slice4
    import csa_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               c
);

    logic [SLICE_W-1:0] s0, s1;
    logic [SLICE_W:0]   cy0, cy1;

    always_comb begin
        s0     = '0;
        s1     = '0;
        cy0    = '0;
        cy1    = '0;
        cy0[0] = 1'b0;
        cy1[0] = 1'b1;
        for (int i = 0; i < SLICE_W; i++) begin
            s0[i]    = a[i] ^ b[i] ^ cy0[i];
            cy0[i+1] = (a[i] & b[i]) | (cy0[i] & (a[i] ^ b[i]));
            s1[i]    = a[i] ^ b[i] ^ cy1[i];
            cy1[i+1] = (a[i] & b[i]) | (cy1[i] & (a[i] ^ b[i]));
        end
    end

    assign s = ci ? s1 : s0;
    assign c = ci ? cy1[SLICE_W] : cy0[SLICE_W];

endmodule

// File: rtl/csa_slice_sequencer.sv
// Multi-cycle W-bit add/subtract that walks one shared 4-bit carry-select
// slice across the operands, least-significant slice first.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | in_ready=1, waiting for an operand packet
//   RUN     | one slice per clock, idx selects the nibble being summed
//   DONE    | out_valid=1, result frozen until out_ready
module csa_slice_sequencer
    import csa_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csa_slice_sequencer_if.slave  bus
);

    localparam int NSLICE = nslice(W);
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    logic [1:0] state, state_nxt;

    logic [NSLICE-1:0][SLICE_W-1:0] opa, opb, sum_r;
    logic                           carry, cout_r, ovf_r;
    logic [IDX_W-1:0]               idx;

    logic [SLICE_W-1:0] sl_s;
    logic               sl_c;
    logic               accept, last;
    logic               in_ready_c, out_valid_c, busy_c;

    assign accept = (state == ST_IDLE) && bus.in_valid;
    assign last   = (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last)          state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = (state == ST_IDLE);
        out_valid_c = (state == ST_DONE);
        busy_c      = (state == ST_RUN) || (state == ST_DONE);
    end

    csa_slice4 u_slice (
        .a  (opa[idx]),
        .b  (opb[idx]),
        .ci (carry),
        .s  (sl_s),
        .c  (sl_c)
    );

    // Subtract is folded into the operand latch: opb holds ~b and carry starts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            opa    <= bus.a;
            opb    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub | bus.cin;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            idx    <= '0;
        end else if (state == ST_RUN) begin
            sum_r[idx] <= sl_s;
            if (last) begin
                cout_r <= sl_c;
                ovf_r  <= (opa[NSLICE-1][SLICE_W-1] ~^ opb[NSLICE-1][SLICE_W-1])
                        & (sl_s[SLICE_W-1] ^ opa[NSLICE-1][SLICE_W-1]);
            end else begin
                carry <= sl_c;
                idx   <= idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_csa_slice_sequencer.sv
// Directed plus randomized bench for csa_slice_sequencer (W=16) against an
// integer-arithmetic reference model.
module tb_csa_slice_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    csa_slice_sequencer_if #(.W(16)) bus ();

    csa_slice_sequencer #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, overflow judged by signed range.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic ci, input logic sb,
                                  output logic [15:0] s, output logic co, output logic ov);
        int     sa, sbv, r;
        longint u;
        sa  = $signed(a);
        sbv = $signed(b);
        if (sb) begin
            s  = a - b;
            co = (a >= b);
            r  = sa - sbv;
        end else begin
            u  = longint'(a) + longint'(b) + longint'(ci);
            s  = u[15:0];
            co = (u > 64'sd65535);
            r  = sa + sbv + int'(ci);
        end
        ov = (r > 32767) || (r < -32768);
    endfunction

    task automatic scramble_inputs();
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 12) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd4);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb);
        logic [15:0] es;
        logic        ec, eo;
        int          n;
        model(a, b, ci, sb, es, ec, eo);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.sub      = sb;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        scramble_inputs();
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        wait_out_valid({tag, ".latency"});
        chk({tag, ".sum"},  32'(bus.sum),  32'(es));
        chk({tag, ".cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, ".ovf"},  32'(bus.ovf),  32'(eo));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".idle_ready"}, 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
        chk({tag, ".sum_hold"},   32'(bus.sum), 32'(es));
    endtask

    initial begin
        logic [15:0] es, ra, rb;
        logic        ec, eo;
        logic [15:0] pick [4];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;

        #2;
        chk("reset.flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
        chk("reset.res",   32'({bus.sum, bus.cout, bus.ovf}), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        do_op("add_5555",   16'h1234, 16'h4321, 1'b0, 1'b0);
        do_op("add_carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
        do_op("add_cin",    16'h00FF, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result must freeze while new operands wait at the input.
        model(16'h1111, 16'h2222, 1'b1, 1'b0, es, ec, eo);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b1; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out_valid("bp.latency");
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            scramble_inputs();
            tick();
            chk("bp.sum",   32'(bus.sum), 32'(es));
            chk("bp.cv",    32'({bus.cout, bus.ovf}), 32'({ec, eo}));
            chk("bp.flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b011);
        end
        bus.a = 16'h8001; bus.b = 16'h8001; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp.idle", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
        tick();
        bus.in_valid = 1'b0;
        chk("bp.accept", 32'({bus.in_ready, bus.busy}), 32'b01);
        model(16'h8001, 16'h8001, 1'b0, 1'b0, es, ec, eo);
        wait_out_valid("bp2.latency");
        chk("bp2.sum",  32'(bus.sum), 32'(es));
        chk("bp2.cv",   32'({bus.cout, bus.ovf}), 32'({ec, eo}));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset in the middle of RUN, two slices in.
        bus.a = 16'hABCD; bus.b = 16'h1234; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        chk("arst.flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
        chk("arst.res",   32'({bus.sum, bus.cout, bus.ovf}), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        do_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);

        pick[0] = 16'h0000;
        pick[1] = 16'h7FFF;
        pick[2] = 16'h8000;
        pick[3] = 16'hFFFF;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            do_op("rand", ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
